// File: rtl/cp0_irq.sv
// Coprocessor-0 interrupt endpoint: samples level IRQs into Cause.IP, masks them with SR,
// raises int_req, captures EPC / sets EXL on take, and serves mfc0/mtc0 for SR, Cause, EPC, PRId.
module cp0_irq #(
  parameter int          HWINT_W  = 6,
  parameter logic [31:0] PRID_VAL = 32'h2019_0001
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [4:0]         i_addr,
  input  logic [31:0]        i_din,
  input  logic [31:0]        i_pc,
  input  logic [HWINT_W-1:0] i_hwint,
  input  logic               i_exl_clr,
  output logic               o_int_req,
  output logic [31:0]        o_epc,
  output logic [31:0]        o_dout
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [HWINT_W-1:0] r_ip;
  logic [HWINT_W-1:0] r_im;
  logic               r_ie;
  logic [29:0]        r_epc;

  logic               w_int_req;
  logic               w_sr_wr;
  logic               w_epc_wr;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;
  logic               w_unused_pc;

  assign w_int_req = (|(r_ip & r_im)) & r_ie & (r_state == ST_NORMAL);

  // A taken interrupt squashes the committing mtc0.
  assign w_sr_wr  = i_we & ~w_int_req & (i_addr == A_SR);
  assign w_epc_wr = i_we & ~w_int_req & (i_addr == A_EPC);

  assign w_unused_pc = ^i_pc[1:0];

  // EXL state: an SR write carrying EXL wins over a simultaneous eret.
  always_comb begin
    w_state_next = r_state;
    if (w_int_req) begin
      w_state_next = ST_HANDLER;
    end else if (w_sr_wr) begin
      w_state_next = i_din[1] ? ST_HANDLER : ST_NORMAL;
    end else if (i_exl_clr) begin
      w_state_next = ST_NORMAL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ip  <= '0;
      r_im  <= '0;
      r_ie  <= 1'b0;
      r_epc <= '0;
    end else begin
      r_ip <= i_hwint;
      if (w_sr_wr) begin
        r_im <= i_din[10 +: HWINT_W];
        r_ie <= i_din[0];
      end
      if (w_int_req) begin
        r_epc <= i_pc[31:2];
      end else if (w_epc_wr) begin
        r_epc <= i_din[31:2];
      end
    end
  end

  always_comb begin
    w_sr                 = '0;
    w_sr[10 +: HWINT_W]  = r_im;
    w_sr[1]              = (r_state == ST_HANDLER);
    w_sr[0]              = r_ie;
    w_cause              = '0;
    w_cause[10 +: HWINT_W] = r_ip;
    case (i_addr)
      A_SR:    o_dout = w_sr;
      A_CAUSE: o_dout = w_cause;
      A_EPC:   o_dout = {r_epc, 2'b00};
      A_PRID:  o_dout = PRID_VAL;
      default: o_dout = 32'h0;
    endcase
  end

  assign o_int_req = w_int_req;
  assign o_epc     = {r_epc, 2'b00};

endmodule

// File: tb/tb_cp0_irq.sv
// Bench for cp0_irq: word-level model of SR/Cause/EPC checked every cycle, plus directed
// literal expectations for the reset, take, mask, squash, eret and async-reset scenarios.
module tb_cp0_irq;

  localparam logic [31:0] PRID = 32'h2019_0001;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] pc;
  logic [5:0]  hwint;
  logic        exl_clr;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] dout;

  int n_total;
  int n_pass;

  // Model state kept as architectural words.
  logic [31:0] m_sr;
  logic [5:0]  m_ip;
  logic [31:0] m_epc;

  cp0_irq dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_we      (we),
    .i_addr    (addr),
    .i_din     (din),
    .i_pc      (pc),
    .i_hwint   (hwint),
    .i_exl_clr (exl_clr),
    .o_int_req (int_req),
    .o_epc     (epc),
    .o_dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_irq();
    return ((m_ip & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] model_dout(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return {16'h0, m_ip, 10'h0};
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sr  <= 32'h0;
      m_ip  <= 6'h0;
      m_epc <= 32'h0;
    end else begin
      if (model_irq()) begin
        m_epc <= pc & 32'hFFFF_FFFC;
        m_sr  <= m_sr | 32'h2;
      end else begin
        if (we && addr == 5'd12) m_sr <= din & 32'h0000_FC03;
        else if (exl_clr)        m_sr <= m_sr & ~32'h2;
        if (we && addr == 5'd14) m_epc <= din & 32'hFFFF_FFFC;
      end
      m_ip <= hwint;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_int_req", {31'h0, int_req}, {31'h0, model_irq()});
      chk("model_epc", epc, m_epc);
      chk("model_dout", dout, model_dout(addr));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0; we = 1'b0; addr = 5'd12; din = 32'h0;
    pc = 32'h0; hwint = 6'h0; exl_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    peek("rst_sr", 5'd12, 32'h0);
    peek("rst_cause", 5'd13, 32'h0);
    chk("rst_int_req", {31'h0, int_req}, 32'h0);
    next();
    peek("rst_epc", 5'd14, 32'h0);
    peek("rst_prid", 5'd15, PRID);

    // Enable timer IRQ and take it
    next();
    we = 1'b1; addr = 5'd12; din = 32'h0000_0401; hwint = 6'b000001; pc = 32'h0000_3010;
    next();
    we = 1'b0;
    peek("take_cause", 5'd13, 32'h0000_0400);
    chk("take_int_req_hi", {31'h0, int_req}, 32'h1);
    next();
    peek("take_epc_dout", 5'd14, 32'h0000_3010);
    chk("take_epc", epc, 32'h0000_3010);
    chk("take_int_req_lo", {31'h0, int_req}, 32'h0);
    peek("take_sr", 5'd12, 32'h0000_0403);

    // eret with IRQ still pending, then squashed EPC write on the re-take
    exl_clr = 1'b1;
    next();
    exl_clr = 1'b0;
    chk("eret_int_req", {31'h0, int_req}, 32'h1);
    we = 1'b1; addr = 5'd14; din = 32'hDEAD_BEEF; pc = 32'h0000_4020;
    next();
    we = 1'b0;
    peek("squash_epc_dout", 5'd14, 32'h0000_4020);
    chk("squash_epc", epc, 32'h0000_4020);
    chk("squash_int_req", {31'h0, int_req}, 32'h0);

    // SR write of EXL=1 overrides simultaneous eret
    exl_clr = 1'b1; we = 1'b1; addr = 5'd12; din = 32'h0000_0403;
    next();
    exl_clr = 1'b0; we = 1'b0;
    peek("override_sr", 5'd12, 32'h0000_0403);
    chk("override_int_req", {31'h0, int_req}, 32'h0);

    // All IRQs asserted but masked off
    we = 1'b1; addr = 5'd12; din = 32'h0000_0001; hwint = 6'b111111;
    next();
    we = 1'b0; addr = 5'd13;
    next();
    peek("mask_cause", 5'd13, 32'h0000_FC00);
    for (int i = 0; i < 20; i++) begin
      next();
      chk("mask_int_req", {31'h0, int_req}, 32'h0);
    end

    // EPC write drops low bits
    we = 1'b1; addr = 5'd14; din = 32'h0000_3007;
    next();
    we = 1'b0;
    chk("epc_wr", epc, 32'h0000_3004);
    peek("epc_wr_dout", 5'd14, 32'h0000_3004);

    // Read-only / unmapped writes ignored
    we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
    next();
    addr = 5'd3;
    next();
    we = 1'b0;
    peek("unmapped_rd", 5'd3, 32'h0);
    peek("cause_ro", 5'd13, 32'h0000_FC00);
    peek("prid_ro", 5'd15, PRID);

    // Async reset while in the handler
    we = 1'b1; addr = 5'd12; din = 32'h0000_0401; hwint = 6'b000001; pc = 32'h0000_5008;
    next();
    we = 1'b0;
    next();
    peek("pre_rst_sr", 5'd12, 32'h0000_0403);
    rst_n = 1'b0;
    peek("async_sr", 5'd12, 32'h0);
    peek("async_cause", 5'd13, 32'h0);
    peek("async_epc", 5'd14, 32'h0);
    chk("async_int_req", {31'h0, int_req}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1; hwint = 6'h0;
    repeat (3) next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
